spi_controller: RTL and testbench

//   SPI controller (initiator) driving the 3-wire write-only SPI interface of spi_peripheral
//   (SCLK, COPI, nCS; mode 0, MSB first, 16-bit frames). Converts a parallel register-write

---
 rtl/spi_controller.sv | 135 +++++++++++++
 tb/tb_spi_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI initiator for the write-only PWM peripheral: turns one register command into a
// 16-bit mode-0 frame {rw, addr, data}, MSB first, with framed nCS and a done pulse.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              copi,
    output logic              ncs
);

    localparam int         FRAME_W  = 1 + ADDR_W + DATA_W;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_H,
        SHIFT_L,
        HOLD,
        GAP
    } state_t;

    state_t               state, state_d;
    logic [7:0]           div_cnt, div_cnt_d;
    logic [3:0]           bit_cnt, bit_cnt_d;
    logic                 last_bit, last_bit_d;
    logic [FRAME_W-1:0]   shift_reg, shift_reg_d;
    logic                 sclk_d, copi_d, ncs_d, done_d;
    logic                 phase_end;

    assign phase_end = (div_cnt == DIV_LAST);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // The final bit still gets a full low phase before HOLD, so nCS spans
    // SETUP + 16 high/low pairs + HOLD; last_bit marks that the low phase is the tail.
    always_comb begin
        state_d     = state;
        div_cnt_d   = div_cnt;
        bit_cnt_d   = bit_cnt;
        last_bit_d  = last_bit;
        shift_reg_d = shift_reg;
        done_d      = 1'b0;

        if (state != IDLE) begin
            div_cnt_d = phase_end ? 8'd0 : div_cnt + 8'd1;
        end

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = SETUP;
                    shift_reg_d = {cmd_write, cmd_addr, cmd_data};
                    bit_cnt_d   = 4'd0;
                    last_bit_d  = 1'b0;
                    div_cnt_d   = 8'd0;
                end
            end
            SETUP: begin
                if (phase_end) state_d = SHIFT_H;
            end
            SHIFT_H: begin
                if (phase_end) begin
                    state_d = SHIFT_L;
                    if (bit_cnt == BIT_LAST) begin
                        last_bit_d = 1'b1;
                    end else begin
                        shift_reg_d = shift_reg << 1;
                        bit_cnt_d   = bit_cnt + 4'd1;
                    end
                end
            end
            SHIFT_L: begin
                if (phase_end) state_d = last_bit ? HOLD : SHIFT_H;
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d     = IDLE;
                    shift_reg_d = '0;
                    bit_cnt_d   = 4'd0;
                    last_bit_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they register glitch-free.
        sclk_d = (state_d == SHIFT_H);
        ncs_d  = (state_d == IDLE) || (state_d == GAP);
        copi_d = ncs_d ? 1'b0 : shift_reg_d[FRAME_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= 4'd0;
            last_bit  <= 1'b0;
            shift_reg <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_cnt_d;
            bit_cnt   <= bit_cnt_d;
            last_bit  <= last_bit_d;
            shift_reg <= shift_reg_d;
            sclk      <= sclk_d;
            copi      <= copi_d;
            ncs       <= ncs_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: drives commands into a CLK_DIV=4 and a CLK_DIV=8
// instance, decodes the SPI wires back into frames and a register file, and compares.
module tb_spi_controller;

    localparam int DIV_A = 4;
    localparam int DIV_B = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       a_valid, a_ready, a_write, a_busy, a_done, a_sclk, a_copi, a_ncs;
    logic [6:0] a_addr;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_write, b_busy, b_done, b_sclk, b_copi, b_ncs;
    logic [6:0] b_addr;
    logic [7:0] b_data;

    spi_controller #(.CLK_DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_write(a_write),
        .cmd_addr(a_addr), .cmd_data(a_data),
        .busy(a_busy), .done(a_done), .sclk(a_sclk), .copi(a_copi), .ncs(a_ncs)
    );

    spi_controller #(.CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(b_write),
        .cmd_addr(b_addr), .cmd_data(b_data),
        .busy(b_busy), .done(b_done), .sclk(b_sclk), .copi(b_copi), .ncs(b_ncs)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected frames per instance, pushed by the driver at the accepting edge.
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    // Register file implied by completed commands vs. the one decoded from the wires.
    logic [7:0] model_regs[128];
    logic [7:0] wire_regs[128];

    // Per-instance state of the wire decoder.
    bit          m_active[2];
    bit          m_phase_ok[2];
    bit          m_copi_ok[2];
    bit          m_held[2];
    logic [15:0] m_bits[2];
    int          m_nbits[2];
    int          m_ncs_cnt[2];
    int          m_run[2];
    int          m_last_done[2];
    logic        m_prev_s[2];
    logic        m_prev_c[2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One decoder step per clock, sampled on the falling edge. A frame opens when nCS drops
    // and closes on done; every sclk level must last exactly div cycles inside the frame.
    task automatic monitorStep(input int i, input logic s, input logic c, input logic n,
                               input logic d, input logic v, input int div);
        logic [15:0] exp_frame;
        bit          have_exp;
        if (rst) begin
            m_active[i] = 1'b0;
            m_held[i]   = 1'b0;
            m_prev_s[i] = 1'b0;
            m_prev_c[i] = 1'b0;
        end else begin
            if (!m_active[i] && n) m_held[i] = m_held[i] && v;
            if (!n && !m_active[i]) begin
                if (m_held[i]) checkOutput("accept_gap", cyc - m_last_done[i], div + 1);
                m_active[i]   = 1'b1;
                m_held[i]     = 1'b0;
                m_bits[i]     = 16'h0;
                m_nbits[i]    = 0;
                m_ncs_cnt[i]  = 0;
                m_run[i]      = 0;
                m_phase_ok[i] = 1'b1;
                m_copi_ok[i]  = 1'b1;
            end
            if (m_active[i] && !n) begin
                m_ncs_cnt[i]++;
                if (s != m_prev_s[i]) begin
                    if (m_run[i] != div) m_phase_ok[i] = 1'b0;
                    m_run[i] = 1;
                    if (s) begin
                        m_bits[i] = {m_bits[i][14:0], c};
                        m_nbits[i]++;
                    end
                end else begin
                    m_run[i]++;
                end
                if (s && m_prev_s[i] && (c != m_prev_c[i])) m_copi_ok[i] = 1'b0;
            end
            if (d) begin
                have_exp = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                if (!have_exp || !m_active[i]) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done inst %0d: got done=1, expected no frame pending", i);
                end else begin
                    if (i == 0) exp_frame = exp_q0.pop_front();
                    else        exp_frame = exp_q1.pop_front();
                    checkOutput("frame", m_bits[i], exp_frame);
                    checkOutput("rise_count", m_nbits[i], 16);
                    checkOutput("ncs_low_cycles", m_ncs_cnt[i], 34 * div);
                    checkOutput("ncs_high_at_done", n, 1);
                    checkOutput("sclk_low_at_done", s, 0);
                    checkOutput("sclk_phase_len", m_phase_ok[i], 1);
                    checkOutput("copi_stable_high", m_copi_ok[i], 1);
                    if (i == 0) begin
                        if (exp_frame[15]) model_regs[exp_frame[14:8]] = exp_frame[7:0];
                        if (m_bits[i][15] && m_nbits[i] == 16) wire_regs[m_bits[i][14:8]] = m_bits[i][7:0];
                    end
                end
                m_active[i]    = 1'b0;
                m_last_done[i] = cyc;
                m_held[i]      = v;
            end else if (m_active[i] && n) begin
                checkOutput("done_at_ncs_rise", d, 1);
                m_active[i] = 1'b0;
            end
            m_prev_s[i] = s;
            m_prev_c[i] = c;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        monitorStep(0, a_sclk, a_copi, a_ncs, a_done, a_valid, DIV_A);
        monitorStep(1, b_sclk, b_copi, b_ncs, b_done, b_valid, DIV_B);
    end

    // Presents one command (called just after a rising edge) and waits for the handshake;
    // with hold set, cmd_valid stays high so the next call queues straight behind it.
    task automatic applyStimulus(input int i, input logic w, input logic [6:0] ad,
                                 input logic [7:0] dt, input bit hold);
        int   waited = 0;
        logic rdy;
        if (i == 0) begin
            a_valid = 1'b1; a_write = w; a_addr = ad; a_data = dt;
        end else begin
            b_valid = 1'b1; b_write = w; b_addr = ad; b_data = dt;
        end
        rdy = (i == 0) ? a_ready : b_ready;
        while (!rdy && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
            rdy = (i == 0) ? a_ready : b_ready;
        end
        checkOutput("accept_ready", rdy, 1);
        if (rdy) begin
            if (i == 0) exp_q0.push_back({w, ad, dt});
            else        exp_q1.push_back({w, ad, dt});
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            if (i == 0) a_valid = 1'b0;
            else        b_valid = 1'b0;
        end
    endtask

    task automatic waitIdle(input int i);
        int   waited = 0;
        logic pend   = 1'b1;
        while (pend && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
            pend = (i == 0) ? (a_busy || exp_q0.size() != 0) : (b_busy || exp_q1.size() != 0);
        end
        checkOutput("idle_reached", pend, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   rises;
        int   waited;
        logic prev;
        logic w;
        logic [6:0] ad;
        logic [7:0] dt;

        for (int k = 0; k < 128; k++) begin
            model_regs[k] = 8'h00;
            wire_regs[k]  = 8'h00;
        end
        rst = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_addr = 7'h0; a_data = 8'h0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 7'h0; b_data = 8'h0;

        // Reset values in the first cycle after release.
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_cmd_ready", a_ready, 1);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_ncs", a_ncs, 1);
        checkOutput("rst_sclk", a_sclk, 0);
        checkOutput("rst_copi", a_copi, 0);
        checkOutput("rst_done", a_done, 0);

        // Single write 0x00 = 0xF0.
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 7'h00, 8'hF0, 1'b0);
        waitIdle(0);
        checkOutput("reg0", wire_regs[0], 8'hF0);

        // Four writes back to back with cmd_valid held.
        applyStimulus(0, 1'b1, 7'h01, 8'hFF, 1'b1);
        applyStimulus(0, 1'b1, 7'h02, 8'h0F, 1'b1);
        applyStimulus(0, 1'b1, 7'h03, 8'hA5, 1'b1);
        applyStimulus(0, 1'b1, 7'h04, 8'h80, 1'b0);
        waitIdle(0);
        checkOutput("reg1", wire_regs[1], 8'hFF);
        checkOutput("reg2", wire_regs[2], 8'h0F);
        checkOutput("reg3", wire_regs[3], 8'hA5);
        checkOutput("reg4", wire_regs[4], 8'h80);

        // Read frame: emitted in full but leaves the register alone.
        applyStimulus(0, 1'b0, 7'h04, 8'h11, 1'b0);
        waitIdle(0);
        checkOutput("reg4_after_read", wire_regs[4], 8'h80);

        // A command offered mid-frame must be dropped, not queued.
        applyStimulus(0, 1'b1, 7'h03, 8'hA5, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        a_valid = 1'b1; a_write = 1'b1; a_addr = 7'h02; a_data = 8'h33;
        checkOutput("ready_low_busy", a_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        waitIdle(0);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("reg2_unchanged", wire_regs[2], 8'h0F);

        // Reset after the fifth sclk rise aborts the frame without a done pulse.
        applyStimulus(0, 1'b1, 7'h04, 8'h55, 1'b0);
        rises = 0; waited = 0; prev = a_sclk;
        while (rises < 5 && waited < 1000) begin
            @(posedge clk);
            #1;
            if (a_sclk && !prev) rises++;
            prev = a_sclk;
            waited++;
        end
        checkOutput("fifth_rise_seen", rises, 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_ncs", a_ncs, 1);
        checkOutput("abort_sclk", a_sclk, 0);
        checkOutput("abort_busy", a_busy, 0);
        checkOutput("abort_done", a_done, 0);
        void'(exp_q0.pop_back());
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("ready_after_abort", a_ready, 1);
        checkOutput("reg4_after_abort", wire_regs[4], 8'h80);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 7'h04, 8'h55, 1'b0);
        waitIdle(0);
        checkOutput("reg4_retry", wire_regs[4], 8'h55);

        // Random mix of reads/writes, some queued back to back.
        for (int k = 0; k < 24; k++) begin
            w  = ($urandom_range(0, 3) != 0);
            ad = 7'($urandom_range(0, 7));
            dt = 8'($urandom_range(0, 255));
            applyStimulus(0, w, ad, dt, ($urandom_range(0, 1) == 1) && (k != 23));
        end
        a_valid = 1'b0;
        waitIdle(0);

        // Slower divider: same frame, double-length phases.
        applyStimulus(1, 1'b1, 7'h00, 8'hF0, 1'b0);
        waitIdle(1);

        for (int k = 0; k < 8; k++) begin
            checkOutput("reg_file", wire_regs[k], model_regs[k]);
        end
        checkOutput("queue0_empty", exp_q0.size(), 0);
        checkOutput("queue1_empty", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
